// File: rtl/opb_s2p_pkg.sv
// Shared constants and types for the simulink-to-PPC readback register.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package opb_s2p_pkg;

  // Word index within the slave window (byte offset / 4)
  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_TS     = 2'd2;

  // Status word bit positions
  localparam int NEW_BIT = 0;
  localparam int OVF_BIT = 1;
  localparam int CNT_LSB = 16;

  typedef enum logic [1:0] {IDLE, ACK, WAIT} fsm_state_t;

  // Pack the status fields into the word the PPC sees
  function automatic logic [31:0] status_word(input logic [15:0] cnt,
                                              input logic        ovf,
                                              input logic        nw);
    logic [31:0] w;
    w                 = '0;
    w[CNT_LSB +: 16]  = cnt;
    w[OVF_BIT]        = ovf;
    w[NEW_BIT]        = nw;
    return w;
  endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave address decode and single-ack handshake (IDLE -> ACK -> WAIT).
// Latency: hit sampled in cycle N, xfer_ack high in cycle N+1 for one cycle.
// Backpressure: none; WAIT holds off re-acking until the master drops select.
module opb_slave_ack_fsm
  import opb_s2p_pkg::*;
#(
  parameter int                      C_OPB_AWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h01100800,
  parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h011008FF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    select,
  input  logic                    rnw,
  input  logic [0:C_OPB_AWIDTH-1] abus,
  output logic                    load,
  output logic [1:0]              hit_idx,
  output logic [1:0]              word_idx,
  output logic                    xfer_ack,
  output logic                    rd_stb,
  output logic                    wr_stb
);

  fsm_state_t state;
  logic       hit;

  // Address window decode; word index comes from byte-address bits 3:2
  assign hit     = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
  assign hit_idx = abus[C_OPB_AWIDTH-4:C_OPB_AWIDTH-3];
  assign load    = (state == IDLE) && hit;

  // Strobes qualify the one ack cycle by transfer direction
  assign rd_stb = xfer_ack && rnw;
  assign wr_stb = xfer_ack && !rnw;

  // Handshake FSM with registered ack and latched word index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      word_idx <= '0;
      xfer_ack <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state    <= ACK;
            word_idx <= hit_idx;
            xfer_ack <= 1'b1;
          end
        end
        ACK: begin
          state    <= WAIT;
          xfer_ack <= 1'b0;
        end
        WAIT: begin
          if (!select) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          xfer_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// Captures a fabric word on user_valid and exposes data/status(/timestamp) to the PPC over OPB; OPB_S2P_TIMESTAMP_EN adds the timestamp word.
// Latency: ack one cycle after a hit; read data reflects register state in the hit cycle.
// Backpressure: none; user_valid is accepted every cycle, unread words set the sticky overflow flag.
module opb_register_simulink2ppc
  import opb_s2p_pkg::*;
#(
  parameter logic [31:0]    C_BASEADDR   = 32'h01100800,
  parameter logic [31:0]    C_HIGHADDR   = 32'h011008FF,
  parameter int             C_OPB_AWIDTH = 32,
  parameter int             C_OPB_DWIDTH = 32,
  parameter logic [127:0]   C_FAMILY     = "virtex6"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic                    Sl_xferAck,
  input  logic [31:0]             user_data_in,
  input  logic                    user_valid
);

  logic        load, rd_stb, wr_stb;
  logic [1:0]  hit_idx, word_idx;
  logic [31:0] data_reg, dbus_hold, rd_word;
  logic        new_flag, ovf_flag;
  logic [15:0] capture_count;
  logic        clr_new, clr_ovf;
  logic        unused_ok;

  opb_slave_ack_fsm #(
    .C_OPB_AWIDTH (C_OPB_AWIDTH),
    .C_BASEADDR   (C_BASEADDR),
    .C_HIGHADDR   (C_HIGHADDR)
  ) u_fsm (
    .clk      (OPB_Clk),
    .rst      (OPB_Rst),
    .select   (OPB_select),
    .rnw      (OPB_RNW),
    .abus     (OPB_ABus),
    .load     (load),
    .hit_idx  (hit_idx),
    .word_idx (word_idx),
    .xfer_ack (Sl_xferAck),
    .rd_stb   (rd_stb),
    .wr_stb   (wr_stb)
  );

  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  // Byte enables, burst hint, family string and unused write bits have no effect
  assign unused_ok = ^{OPB_BE, OPB_seqAddr, OPB_DBus[0:C_OPB_DWIDTH-3],
                       OPB_DBus[C_OPB_DWIDTH-1], C_FAMILY};

  // Side effects land in the ack cycle, using the index latched at the hit
  assign clr_new = rd_stb && (word_idx == OFF_DATA);
  assign clr_ovf = wr_stb && (word_idx == OFF_STATUS) && OPB_DBus[C_OPB_DWIDTH-2];

`ifdef OPB_S2P_TIMESTAMP_EN
  logic [31:0] cycle_cnt, ts_reg;

  // Free-running cycle counter, latched alongside every captured word
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      cycle_cnt <= '0;
      ts_reg    <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (user_valid) ts_reg <= cycle_cnt;
    end
  end
`endif

  // Read mux selected by the address presented in the hit cycle
  always_comb begin
    rd_word = '0;
    case (hit_idx)
      OFF_DATA:   rd_word = data_reg;
      OFF_STATUS: rd_word = status_word(capture_count, ovf_flag, new_flag);
`ifdef OPB_S2P_TIMESTAMP_EN
      OFF_TS:     rd_word = ts_reg;
`endif
      default:    rd_word = '0;
    endcase
  end

  // Hold the read word from the hit cycle so a same-cycle capture is not seen
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) dbus_hold <= '0;
    else if (load) dbus_hold <= rd_word;
  end

  // Drive the bus only while acking a read so slaves can be ORed
  assign Sl_DBus = rd_stb ? dbus_hold : '0;

  // Capture path and flag updates; a capture beats a clear of the same flag
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      data_reg      <= '0;
      new_flag      <= 1'b0;
      ovf_flag      <= 1'b0;
      capture_count <= '0;
    end else begin
      if (clr_ovf) ovf_flag <= 1'b0;
      if (user_valid) begin
        data_reg      <= user_data_in;
        new_flag      <= 1'b1;
        capture_count <= capture_count + 16'd1;
        if (new_flag && !clr_new) ovf_flag <= 1'b1;
      end else if (clr_new) begin
        new_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Self-checking bench for opb_register_simulink2ppc; reads go through an expected-data queue.
// Latency: expects the ack exactly one cycle after select.
// Backpressure: n/a.
module tb_opb_register_simulink2ppc;

  localparam logic [31:0] BASE = 32'h01100800;
  localparam logic [31:0] HIGH = 32'h011008FF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:31] OPB_ABus = '0;
  logic [0:3]  OPB_BE = '0;
  logic [0:31] OPB_DBus = '0;
  logic        OPB_RNW = 1'b0;
  logic        OPB_select = 1'b0;
  logic        OPB_seqAddr = 1'b0;
  logic [0:31] Sl_DBus;
  logic        Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck;
  logic [31:0] user_data_in = '0;
  logic        user_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mdata, mts;
  logic        mnew, movf;
  logic [15:0] mcnt;
  logic [31:0] exp_q[$];
  logic [31:0] cyc;

  always #5 clk = ~clk;

  // Reference free-running cycle counter
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 32'd1;
  end

  opb_register_simulink2ppc dut (
    .OPB_Clk      (clk),
    .OPB_Rst      (rst),
    .OPB_ABus     (OPB_ABus),
    .OPB_BE       (OPB_BE),
    .OPB_DBus     (OPB_DBus),
    .OPB_RNW      (OPB_RNW),
    .OPB_select   (OPB_select),
    .OPB_seqAddr  (OPB_seqAddr),
    .Sl_DBus      (Sl_DBus),
    .Sl_errAck    (Sl_errAck),
    .Sl_retry     (Sl_retry),
    .Sl_toutSup   (Sl_toutSup),
    .Sl_xferAck   (Sl_xferAck),
    .user_data_in (user_data_in),
    .user_valid   (user_valid)
  );

  function automatic logic [31:0] model_word(input logic [1:0] idx);
    case (idx)
      2'd0: return mdata;
      2'd1: return {mcnt, 14'b0, movf, mnew};
`ifdef OPB_S2P_TIMESTAMP_EN
      2'd2: return mts;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step(input logic cap, input logic [31:0] cd, input logic [31:0] cts,
                            input logic clr_new, input logic clr_ovf);
    if (clr_ovf) movf = 1'b0;
    if (cap) begin
      if (mnew && !clr_new) movf = 1'b1;
      mnew  = 1'b1;
      mdata = cd;
      mcnt  = mcnt + 16'd1;
      mts   = cts;
    end else if (clr_new) begin
      mnew = 1'b0;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    OPB_select = 1'b0;
    OPB_RNW = 1'b0;
    user_valid = 1'b0;
    repeat (2) @(posedge clk);
    mdata = '0; mts = '0; mnew = 1'b0; movf = 1'b0; mcnt = '0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One OPB transfer holding select for 'hold' cycles (>= 2); optional capture during the ack cycle
  task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [31:0] wdata,
                      input int hold, input logic cap, input logic [31:0] cdata, input string name);
    logic        hit;
    int          acks;
    int          first;
    logic [31:0] cts;
    logic [31:0] exp;
    hit   = (addr >= BASE) && (addr <= HIGH);
    acks  = 0;
    first = -1;
    cts   = '0;
    @(posedge clk); #1;
    OPB_ABus   = addr;
    OPB_RNW    = rnw;
    OPB_DBus   = wdata;
    OPB_select = 1'b1;
    if (hit && rnw) exp_q.push_back(model_word(addr[3:2]));
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      checks++;
      if (Sl_xferAck === 1'b1) begin
        acks++;
        if (first < 0) first = c;
        if (rnw) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_data: ack with nothing expected, got %h", name, Sl_DBus);
          end else begin
            exp = exp_q.pop_front();
            if (Sl_DBus !== exp) begin
              errors++;
              $display("FAIL %s_data: got %h expected %h", name, Sl_DBus, exp);
            end
          end
        end else if (Sl_DBus !== 32'h0) begin
          errors++;
          $display("FAIL %s_wr_dbus: got %h expected 00000000", name, Sl_DBus);
        end
      end else if (Sl_DBus !== 32'h0) begin
        errors++;
        $display("FAIL %s_idle_dbus: cycle %0d got %h expected 00000000", name, c, Sl_DBus);
      end
      @(posedge clk); #1;
      if (cap && c == 0) begin
        user_valid   = 1'b1;
        user_data_in = cdata;
        cts          = cyc;
      end
      if (cap && c == 1) user_valid = 1'b0;
    end
    OPB_select = 1'b0;
    OPB_RNW    = 1'b0;
    OPB_DBus   = '0;
    checks++;
    if (acks != (hit ? 1 : 0)) begin
      errors++;
      $display("FAIL %s_ack_count: got %0d expected %0d", name, acks, hit ? 1 : 0);
    end
    if (hit) begin
      checks++;
      if (first != 1) begin
        errors++;
        $display("FAIL %s_ack_latency: got %0d expected 1", name, first);
      end
      model_step(cap, cdata, cts, rnw && addr[3:2] == 2'd0,
                 !rnw && addr[3:2] == 2'd1 && wdata[1]);
    end
  endtask

  // n consecutive capture cycles with data base+i
  task automatic cap_burst(input int n, input logic [31:0] base);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      user_valid   = 1'b1;
      user_data_in = base + 32'(i);
      model_step(1'b1, base + 32'(i), cyc, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    user_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (Sl_xferAck !== 1'b0 || Sl_DBus !== 32'h0 || Sl_errAck !== 1'b0 ||
        Sl_retry !== 1'b0 || Sl_toutSup !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b dbus=%h err=%b retry=%b tout=%b expected all 0",
               Sl_xferAck, Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup);
    end
    do_reset();
    xfer(BASE,         1'b1, 32'h0, 2, 1'b0, 32'h0, "reset_data");
    xfer(BASE + 32'h4, 1'b1, 32'h0, 2, 1'b0, 32'h0, "reset_status");
  endtask

  task automatic test_capture_read;
    cap_burst(1, 32'hDEADBEEF);
    xfer(BASE,         1'b1, 32'h0, 2, 1'b0, 32'h0, "cap_data");
    xfer(BASE + 32'h4, 1'b1, 32'h0, 2, 1'b0, 32'h0, "cap_status");
  endtask

  task automatic test_overflow;
    cap_burst(1, 32'h1);
    cap_burst(1, 32'h2);
    xfer(BASE + 32'h4, 1'b1, 32'h0, 2, 1'b0, 32'h0, "ovf_status");
    xfer(BASE,         1'b1, 32'h0, 2, 1'b0, 32'h0, "ovf_data");
    xfer(BASE + 32'h4, 1'b0, 32'h2, 2, 1'b0, 32'h0, "ovf_w1c");
    xfer(BASE + 32'h4, 1'b1, 32'h0, 2, 1'b0, 32'h0, "ovf_after_w1c");
  endtask

  task automatic test_simultaneous;
    cap_burst(1, 32'h11112222);
    xfer(BASE,         1'b1, 32'h0, 2, 1'b1, 32'h33334444, "sim_rd_cap");
    xfer(BASE + 32'h4, 1'b1, 32'h0, 2, 1'b0, 32'h0, "sim_rd_status");
    xfer(BASE + 32'h4, 1'b0, 32'h2, 2, 1'b1, 32'h55556666, "sim_w1c_cap");
    xfer(BASE + 32'h4, 1'b1, 32'h0, 2, 1'b0, 32'h0, "sim_w1c_status");
    xfer(BASE,         1'b1, 32'h0, 2, 1'b0, 32'h0, "sim_data");
  endtask

  task automatic test_hold_and_miss;
    xfer(BASE,           1'b1, 32'h0,      5, 1'b0, 32'h0, "hold5");
    xfer(32'h01100900,   1'b1, 32'h0,      3, 1'b0, 32'h0, "miss_high");
    xfer(32'h011007FC,   1'b1, 32'h0,      3, 1'b0, 32'h0, "miss_low");
    xfer(BASE + 32'hC,   1'b1, 32'h0,      2, 1'b0, 32'h0, "off_c");
    xfer(BASE + 32'hFC,  1'b1, 32'h0,      2, 1'b0, 32'h0, "alias_top");
    xfer(BASE,           1'b0, 32'hFFFFFFFF, 2, 1'b0, 32'h0, "wr_data_noeffect");
    xfer(BASE + 32'h4,   1'b1, 32'h0,      2, 1'b0, 32'h0, "status_after_wr");
  endtask

  task automatic test_mid_reset;
    @(posedge clk); #1;
    OPB_ABus   = BASE;
    OPB_RNW    = 1'b1;
    OPB_select = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (Sl_xferAck !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre_ack: got %b expected 1", Sl_xferAck);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (Sl_xferAck !== 1'b0 || Sl_DBus !== 32'h0) begin
      errors++;
      $display("FAIL midrst_drop: ack=%b dbus=%h expected 0/00000000", Sl_xferAck, Sl_DBus);
    end
    do_reset();
    xfer(BASE + 32'h4, 1'b1, 32'h0, 2, 1'b0, 32'h0, "midrst_status");
  endtask

  task automatic test_wrap;
    cap_burst(65535, 32'h0);
    xfer(BASE + 32'h4, 1'b1, 32'h0, 2, 1'b0, 32'h0, "wrap_ffff");
    cap_burst(1, 32'hCAFE0000);
    xfer(BASE + 32'h4, 1'b1, 32'h0, 2, 1'b0, 32'h0, "wrap_zero");
    xfer(BASE,         1'b1, 32'h0, 2, 1'b0, 32'h0, "wrap_data");
  endtask

  task automatic test_timestamp;
    bit found;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (cyc == 32'd100) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL ts_wait: counter 100 not reached, at %0d", cyc);
    end
    user_valid   = 1'b1;
    user_data_in = 32'h0BADF00D;
    model_step(1'b1, 32'h0BADF00D, cyc, 1'b0, 1'b0);
    @(posedge clk); #1;
    user_valid = 1'b0;
    xfer(BASE + 32'h8, 1'b1, 32'h0, 2, 1'b0, 32'h0, "ts_read");
  endtask

  initial begin
    test_reset();
    test_capture_read();
    test_overflow();
    test_simultaneous();
    test_hold_and_miss();
    test_mid_reset();
    test_wrap();
    test_timestamp();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
